// File: rtl/vehicle_lane_demux.sv
// Serial 1-to-4 lane loader: pattern bits are shifted into the selected lane; once all lanes
// are full the block rotates them on each movement tick. Optional build macro: VEHICLE_LANE_DEMUX_ALT_DIRECTION_EN.
module vehicle_lane_demux #(
   parameter int DATAWIDTH_SELECTOR = 2,
   parameter int LANE_WIDTH         = 8
) (
   input  logic                          VEHICLE_LANE_DEMUX_CLOCK_50,
   input  logic                          VEHICLE_LANE_DEMUX_RESET_InLow,
   input  logic [DATAWIDTH_SELECTOR-1:0] VEHICLE_LANE_DEMUX_SELECT_BUS_IN,
   input  logic                          VEHICLE_LANE_DEMUX_BIT_IN,
   input  logic                          VEHICLE_LANE_DEMUX_LOAD_IN,
   output logic                          VEHICLE_LANE_DEMUX_LOAD_READY_OUT,
   input  logic                          VEHICLE_LANE_DEMUX_SHIFT_TICK_IN,
   input  logic                          VEHICLE_LANE_DEMUX_CLEAR_IN,
   output logic [LANE_WIDTH-1:0]         VEHICLE_LANE_DEMUX_LANE0_BUS_OUT,
   output logic [LANE_WIDTH-1:0]         VEHICLE_LANE_DEMUX_LANE1_BUS_OUT,
   output logic [LANE_WIDTH-1:0]         VEHICLE_LANE_DEMUX_LANE2_BUS_OUT,
   output logic [LANE_WIDTH-1:0]         VEHICLE_LANE_DEMUX_LANE3_BUS_OUT,
   output logic [3:0]                    VEHICLE_LANE_DEMUX_LANE_FULL_OUT,
   output logic                          VEHICLE_LANE_DEMUX_RUN_OUT
);

   localparam int CNT_W = $clog2(LANE_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LANE_WIDTH);

   typedef enum logic {
      ST_LOAD,
      ST_RUN
   } state_e;

   state_e                state_q, state_d;
   logic [LANE_WIDTH-1:0] lane_q [4];
   logic [LANE_WIDTH-1:0] lane_d [4];
   logic [CNT_W-1:0]      cnt_q  [4];
   logic [CNT_W-1:0]      cnt_d  [4];
   logic [3:0]            full;
   logic                  ready;
   logic                  transfer;
   logic                  allFull_d;
   logic [1:0]            sel;

   assign sel = VEHICLE_LANE_DEMUX_SELECT_BUS_IN[1:0];

   function automatic logic [LANE_WIDTH-1:0] rotLeft(input logic [LANE_WIDTH-1:0] v);
      return {v[LANE_WIDTH-2:0], v[LANE_WIDTH-1]};
   endfunction

   function automatic logic [LANE_WIDTH-1:0] rotRight(input logic [LANE_WIDTH-1:0] v);
      return {v[0], v[LANE_WIDTH-1:1]};
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_full
      assign full[g] = (cnt_q[g] == CNT_MAX);
   end

   // Ready is forced low while reset is held so the source never sees a phantom slot.
   assign ready    = VEHICLE_LANE_DEMUX_RESET_InLow && (state_q == ST_LOAD) && !full[sel];
   assign transfer = VEHICLE_LANE_DEMUX_LOAD_IN && ready;

   always_comb begin
      state_d   = state_q;
      allFull_d = 1'b0;
      for (int i = 0; i < 4; i++) begin
         lane_d[i] = lane_q[i];
         cnt_d[i]  = cnt_q[i];
      end
      if (VEHICLE_LANE_DEMUX_CLEAR_IN) begin
         state_d = ST_LOAD;
         for (int i = 0; i < 4; i++) begin
            lane_d[i] = '0;
            cnt_d[i]  = '0;
         end
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (transfer) begin
                  lane_d[sel] = {lane_q[sel][LANE_WIDTH-2:0], VEHICLE_LANE_DEMUX_BIT_IN};
                  cnt_d[sel]  = cnt_q[sel] + CNT_W'(1);
                  allFull_d   = 1'b1;
                  for (int i = 0; i < 4; i++) begin
                     if (cnt_d[i] != CNT_MAX) allFull_d = 1'b0;
                  end
                  if (allFull_d) state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (VEHICLE_LANE_DEMUX_SHIFT_TICK_IN) begin
                  for (int i = 0; i < 4; i++) begin
`ifdef VEHICLE_LANE_DEMUX_ALT_DIRECTION_EN
                     lane_d[i] = ((i % 2) == 1) ? rotRight(lane_q[i]) : rotLeft(lane_q[i]);
`else
                     lane_d[i] = rotLeft(lane_q[i]);
`endif
                  end
               end
            end
            default: state_d = ST_LOAD;
         endcase
      end
   end

   always_ff @(posedge VEHICLE_LANE_DEMUX_CLOCK_50 or negedge VEHICLE_LANE_DEMUX_RESET_InLow) begin
      if (!VEHICLE_LANE_DEMUX_RESET_InLow) begin
         state_q <= ST_LOAD;
         for (int i = 0; i < 4; i++) begin
            lane_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
      end else begin
         state_q <= state_d;
         for (int i = 0; i < 4; i++) begin
            lane_q[i] <= lane_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
      end
   end

   assign VEHICLE_LANE_DEMUX_LOAD_READY_OUT = ready;
   assign VEHICLE_LANE_DEMUX_LANE0_BUS_OUT  = lane_q[0];
   assign VEHICLE_LANE_DEMUX_LANE1_BUS_OUT  = lane_q[1];
   assign VEHICLE_LANE_DEMUX_LANE2_BUS_OUT  = lane_q[2];
   assign VEHICLE_LANE_DEMUX_LANE3_BUS_OUT  = lane_q[3];
   assign VEHICLE_LANE_DEMUX_LANE_FULL_OUT  = full;
   assign VEHICLE_LANE_DEMUX_RUN_OUT        = (state_q == ST_RUN);

endmodule

// File: tb/tb_vehicle_lane_demux.sv
// Scoreboard bench for vehicle_lane_demux: a behavioural model pushes expected lane state
// for every driven cycle and a monitor pops and compares it just after the clock edge.
module tb_vehicle_lane_demux;

   localparam int LW = 8;

   typedef struct packed {
      logic [3:0][LW-1:0] lanes;
      logic [3:0]         full;
      logic               run;
   } sbEntry_t;

   logic          clk = 1'b0;
   logic          rstN;
   logic [1:0]    sel;
   logic          bitIn, loadIn, tickIn, clearIn;
   logic          readyOut, runOut;
   logic [LW-1:0] lane0, lane1, lane2, lane3;
   logic [3:0]    fullOut;

   int            testsRun = 0;
   int            testsFailed = 0;
   sbEntry_t      sbQueue[$];
   sbEntry_t      monEntry;
   logic [LW-1:0] mLane [4];
   int            mCnt  [4];
   logic          mRun;

   vehicle_lane_demux #(.DATAWIDTH_SELECTOR(2), .LANE_WIDTH(LW)) dut (
      .VEHICLE_LANE_DEMUX_CLOCK_50      (clk),
      .VEHICLE_LANE_DEMUX_RESET_InLow   (rstN),
      .VEHICLE_LANE_DEMUX_SELECT_BUS_IN (sel),
      .VEHICLE_LANE_DEMUX_BIT_IN        (bitIn),
      .VEHICLE_LANE_DEMUX_LOAD_IN       (loadIn),
      .VEHICLE_LANE_DEMUX_LOAD_READY_OUT(readyOut),
      .VEHICLE_LANE_DEMUX_SHIFT_TICK_IN (tickIn),
      .VEHICLE_LANE_DEMUX_CLEAR_IN      (clearIn),
      .VEHICLE_LANE_DEMUX_LANE0_BUS_OUT (lane0),
      .VEHICLE_LANE_DEMUX_LANE1_BUS_OUT (lane1),
      .VEHICLE_LANE_DEMUX_LANE2_BUS_OUT (lane2),
      .VEHICLE_LANE_DEMUX_LANE3_BUS_OUT (lane3),
      .VEHICLE_LANE_DEMUX_LANE_FULL_OUT (fullOut),
      .VEHICLE_LANE_DEMUX_RUN_OUT       (runOut)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic resetModel();
      for (int i = 0; i < 4; i++) begin
         mLane[i] = '0;
         mCnt[i]  = 0;
      end
      mRun = 1'b0;
   endtask

   task automatic applyStimulus(input logic [1:0] s, input logic b, input logic ld,
                                input logic tk, input logic cl);
      logic     mReady;
      sbEntry_t e;
      @(negedge clk);
      sel = s; bitIn = b; loadIn = ld; tickIn = tk; clearIn = cl;
      #1;
      mReady = !mRun && (mCnt[s] < LW);
      checkOutput("ready", {31'b0, readyOut}, {31'b0, mReady});
      if (cl) begin
         resetModel();
      end else if (!mRun) begin
         if (ld && mReady) begin
            mLane[s] = {mLane[s][LW-2:0], b};
            mCnt[s]++;
            if (mCnt[0] == LW && mCnt[1] == LW && mCnt[2] == LW && mCnt[3] == LW) mRun = 1'b1;
         end
      end else if (tk) begin
         for (int i = 0; i < 4; i++) begin
`ifdef VEHICLE_LANE_DEMUX_ALT_DIRECTION_EN
            if (i == 1 || i == 3) mLane[i] = (mLane[i] >> 1) | (mLane[i] << (LW - 1));
            else                  mLane[i] = (mLane[i] << 1) | (mLane[i] >> (LW - 1));
`else
            mLane[i] = (mLane[i] << 1) | (mLane[i] >> (LW - 1));
`endif
         end
      end
      for (int i = 0; i < 4; i++) begin
         e.lanes[i] = mLane[i];
         e.full[i]  = (mCnt[i] == LW);
      end
      e.run = mRun;
      sbQueue.push_back(e);
      @(posedge clk);
      #2;
      loadIn = 1'b0; tickIn = 1'b0; clearIn = 1'b0;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sbQueue.size() != 0) begin
            monEntry = sbQueue.pop_front();
            checkOutput("sbLane0", {24'b0, lane0}, {24'b0, monEntry.lanes[0]});
            checkOutput("sbLane1", {24'b0, lane1}, {24'b0, monEntry.lanes[1]});
            checkOutput("sbLane2", {24'b0, lane2}, {24'b0, monEntry.lanes[2]});
            checkOutput("sbLane3", {24'b0, lane3}, {24'b0, monEntry.lanes[3]});
            checkOutput("sbFull",  {28'b0, fullOut}, {28'b0, monEntry.full});
            checkOutput("sbRun",   {31'b0, runOut}, {31'b0, monEntry.run});
         end
      end
   end

   initial begin
      logic [7:0] patB1;
      logic [7:0] pat81;
      patB1 = 8'hB1;
      pat81 = 8'h81;
      rstN = 1'b0; sel = 2'd0; bitIn = 1'b0; loadIn = 1'b0; tickIn = 1'b0; clearIn = 1'b0;
      resetModel();
      #12;
      checkOutput("rstLane0", {24'b0, lane0}, 32'h0);
      checkOutput("rstLane3", {24'b0, lane3}, 32'h0);
      checkOutput("rstFull",  {28'b0, fullOut}, 32'h0);
      checkOutput("rstRun",   {31'b0, runOut}, 32'h0);
      checkOutput("rstReady", {31'b0, readyOut}, 32'h0);
      @(negedge clk);
      rstN = 1'b1;
      #1;
      checkOutput("relReady", {31'b0, readyOut}, 32'h1);

      for (int i = 7; i >= 0; i--) applyStimulus(2'd0, patB1[i], 1'b1, 1'b0, 1'b0);
      applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("lane0Loaded", {24'b0, lane0}, 32'hB1);
      checkOutput("full0",       {28'b0, fullOut}, 32'h1);
      applyStimulus(2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("lane0Held",   {24'b0, lane0}, 32'hB1);
      applyStimulus(2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("tickInLoad",  {24'b0, lane0}, 32'hB1);

      for (int b = 7; b >= 0; b--)
         for (int l = 1; l <= 3; l++) applyStimulus(2'(l), pat81[b], 1'b1, 1'b0, 1'b0);
      checkOutput("runRise",  {31'b0, runOut}, 32'h1);
      checkOutput("fullAll",  {28'b0, fullOut}, 32'hF);
      checkOutput("readyRun", {31'b0, readyOut}, 32'h0);
      applyStimulus(2'd1, 1'b1, 1'b1, 1'b0, 1'b0);

      applyStimulus(2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("tick1Lane0", {24'b0, lane0}, 32'h63);
`ifdef VEHICLE_LANE_DEMUX_ALT_DIRECTION_EN
      checkOutput("tick1Lane1", {24'b0, lane1}, 32'hC0);
`else
      checkOutput("tick1Lane1", {24'b0, lane1}, 32'h03);
`endif
      for (int t = 0; t < 7; t++) applyStimulus(2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("wrapLane0", {24'b0, lane0}, 32'hB1);
      checkOutput("wrapLane1", {24'b0, lane1}, 32'h81);
      checkOutput("wrapLane3", {24'b0, lane3}, 32'h81);

      applyStimulus(2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("clrLane0", {24'b0, lane0}, 32'h0);
      checkOutput("clrRun",   {31'b0, runOut}, 32'h0);
      checkOutput("clrFull",  {28'b0, fullOut}, 32'h0);

      for (int i = 0; i < 3; i++) applyStimulus(2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("partLane2", {24'b0, lane2}, 32'h07);
      @(negedge clk);
      #3;
      rstN = 1'b0;
      #1;
      checkOutput("asyncLane2", {24'b0, lane2}, 32'h0);
      checkOutput("asyncFull",  {28'b0, fullOut}, 32'h0);
      checkOutput("asyncReady", {31'b0, readyOut}, 32'h0);
      checkOutput("asyncRun",   {31'b0, runOut}, 32'h0);
      resetModel();
      @(negedge clk);
      rstN = 1'b1;
      applyStimulus(2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("relLane2", {24'b0, lane2}, 32'h0);

      repeat (2) @(negedge clk);
      checkOutput("sbEmpty", sbQueue.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
